// File: rtl/instruction_loader.sv
// instruction_loader
//   Collects instruction bytes, most significant byte first, from a byte
//   source using a valid/ready handshake. It assembles them into words and
//   writes each word to instruction memory at consecutive addresses, starting
//   at address 0.
//
//   Ports
//     clk, reset_n      single clock; asynchronous active-low reset
//     start, word_count load request and word count, sampled in IDLE
//                       (a count above 2**ADDR_WIDTH is clamped)
//     byte_valid/_data  byte source; byte_ready is high only in COLLECT
//     mem_write_enable  one-cycle write strobe, raised in WRITE
//     mem_address       word address of the write
//     mem_write_data    assembled word, held between writes
//     busy, done        busy outside IDLE; done is a one-cycle pulse in DONE
//     words_written     words written in the current or last load
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; words_written holds the last result
//   COLLECT | accepting bytes of the current word
//   WRITE   | strobing the assembled word into memory
//   DONE    | one-cycle completion pulse, then back to IDLE
module instruction_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [WORD_WIDTH-1:0] mem_write_data,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   words_written
);

   localparam int BYTES = WORD_WIDTH / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES - 1);
   localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      byte_idx;
   logic [ADDR_WIDTH:0]   count;
   logic [WORD_WIDTH-1:0] shift;
   logic [ADDR_WIDTH:0]   words_inc;
   logic [WORD_WIDTH-1:0] shift_nxt;
   logic                  accept;
   logic                  last_byte;

   assign accept    = (state == COLLECT) && byte_valid;
   assign last_byte = (byte_idx == LAST_IDX);
   assign words_inc = words_written + 1'b1;
   // Shifting in at the bottom places byte k at bits [W-1-8k -: 8] once a
   // whole word has been collected; older contents fall off the top.
   assign shift_nxt = {shift[WORD_WIDTH-9:0], byte_data};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      byte_ready       = 1'b0;
      mem_write_enable = 1'b0;
      busy             = 1'b1;
      done             = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = (word_count == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            byte_ready = 1'b1;
            if (accept && last_byte) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            mem_write_enable = 1'b1;
            state_nxt = (words_inc == count) ? DONE : COLLECT;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_idx       <= '0;
         count          <= '0;
         shift          <= '0;
         mem_address    <= '0;
         mem_write_data <= '0;
         words_written  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  words_written <= '0;
                  if (word_count != '0) begin
                     count       <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
                     mem_address <= '0;
                     byte_idx    <= '0;
                  end
               end
            end
            COLLECT: begin
               if (accept) begin
                  shift    <= shift_nxt;
                  byte_idx <= byte_idx + 1'b1;
                  if (last_byte) begin
                     mem_write_data <= shift_nxt;
                  end
               end
            end
            WRITE: begin
               // After the last word of a full-size load the address wraps to 0.
               mem_address   <= mem_address + 1'b1;
               words_written <= words_inc;
               byte_idx      <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader
//   Directed bench for instruction_loader: single-word load, stalled
//   multi-word load, empty load, clamped full-size load, reset mid-load and
//   start pulsed while busy.
module tb_instruction_loader;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [8:0]  word_count;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_write_enable;
   logic [7:0]  mem_address;
   logic [31:0] mem_write_data;
   logic        busy;
   logic        done;
   logic [8:0]  words_written;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]  log_addr[$];
   logic [31:0] log_data[$];
   int          done_cnt = 0;

   instruction_loader #(.ADDR_WIDTH(8), .WORD_WIDTH(32)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .word_count       (word_count),
      .byte_valid       (byte_valid),
      .byte_data        (byte_data),
      .byte_ready       (byte_ready),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .busy             (busy),
      .done             (done),
      .words_written    (words_written)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_write_enable) begin
         log_addr.push_back(mem_address);
         log_data.push_back(mem_write_data);
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      done_cnt = 0;
   endtask

   task automatic start_load(input logic [8:0] wc);
      start      = 1'b1;
      word_count = wc;
      tick();
      start      = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      tick();
      byte_valid = 1'b0;
   endtask

   // Four back-to-back bytes, then the WRITE cycle.
   task automatic send_word_fast(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
      tick();
   endtask

   // One idle cycle after every byte; the idle after byte 3 is the WRITE cycle.
   task automatic send_word_slow(input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         send_byte(w[31-8*k -: 8]);
         tick();
      end
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] slow_words[3];
      slow_words[0] = 32'h11223344;
      slow_words[1] = 32'hA5A50F0F;
      slow_words[2] = 32'hDEADBEEF;

      reset_n    = 1'b0;
      start      = 1'b0;
      word_count = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      #2;
      check("rst_busy",   busy,             32'd0);
      check("rst_ready",  byte_ready,       32'd0);
      check("rst_we",     mem_write_enable, 32'd0);
      check("rst_done",   done,             32'd0);
      check("rst_addr",   mem_address,      32'd0);
      check("rst_data",   mem_write_data,   32'd0);
      check("rst_words",  words_written,    32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // single word, back-to-back bytes
      clear_log();
      start_load(9'd1);
      check("t1_ready", byte_ready, 32'd1);
      check("t1_busy",  busy,       32'd1);
      send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
      check("t1_we",    mem_write_enable, 32'd1);
      check("t1_addr",  mem_address,      32'd0);
      check("t1_data",  mem_write_data,   32'h20080005);
      check("t1_nordy", byte_ready,       32'd0);
      tick();
      check("t1_done",  done,             32'd1);
      check("t1_we_off",mem_write_enable, 32'd0);
      check("t1_words", words_written,    32'd1);
      tick();
      check("t1_done_off", done,          32'd0);
      check("t1_idle",     busy,          32'd0);
      check("t1_hold",     words_written, 32'd1);
      check("t1_hold_data",mem_write_data,32'h20080005);
      check("t1_nwr",      log_addr.size(), 32'd1);
      check("t1_ndone",    done_cnt,        32'd1);

      // three words, byte_valid toggling
      clear_log();
      start_load(9'd3);
      for (int i = 0; i < 3; i++) send_word_slow(slow_words[i]);
      check("t2_done",  done,          32'd1);
      check("t2_words", words_written, 32'd3);
      tick();
      check("t2_nwr",   log_addr.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t2_addr%0d", i), (log_addr.size() > i) ? log_addr[i] : 8'hxx, i);
         check($sformatf("t2_data%0d", i), (log_data.size() > i) ? log_data[i] : 32'hxxxxxxxx, slow_words[i]);
      end
      check("t2_ndone", done_cnt, 32'd1);

      // empty load
      clear_log();
      start_load(9'd0);
      check("t3_busy",  busy,          32'd1);
      check("t3_done",  done,          32'd1);
      check("t3_words", words_written, 32'd0);
      tick();
      check("t3_idle",  busy,          32'd0);
      check("t3_done_off", done,       32'd0);
      check("t3_nwr",   log_addr.size(), 32'd0);

      // clamped full-size load
      clear_log();
      start_load(9'd300);
      for (int i = 0; i < 256; i++) begin
         w = {i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'h3C};
         for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
         if (i == 255) begin
            check("t4_last_we",   mem_write_enable, 32'd1);
            check("t4_last_addr", mem_address,      32'd255);
         end
         tick();
      end
      check("t4_done",  done,          32'd1);
      check("t4_words", words_written, 32'd256);
      check("t4_wrap",  mem_address,   32'd0);
      tick();
      check("t4_idle",  busy,          32'd0);
      check("t4_nwr",   log_addr.size(), 32'd256);
      check("t4_ndone", done_cnt,      32'd1);
      begin
         int bad_addr = 0;
         int bad_data = 0;
         for (int i = 0; i < log_addr.size() && i < 256; i++) begin
            w = {i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'h3C};
            if (log_addr[i] !== i[7:0]) bad_addr++;
            if (log_data[i] !== w) bad_data++;
         end
         check("t4_bad_addr", bad_addr, 32'd0);
         check("t4_bad_data", bad_data, 32'd0);
      end

      // reset after the 2nd byte of the second word
      clear_log();
      start_load(9'd2);
      send_word_fast(32'hCAFEF00D);
      check("t5_addr1", mem_address, 32'd1);
      send_byte(8'h12);
      send_byte(8'h34);
      clear_log();
      reset_n = 1'b0;
      #1;
      check("t5_busy",  busy,             32'd0);
      check("t5_ready", byte_ready,       32'd0);
      check("t5_we",    mem_write_enable, 32'd0);
      check("t5_done",  done,             32'd0);
      check("t5_addr",  mem_address,      32'd0);
      check("t5_data",  mem_write_data,   32'd0);
      check("t5_words", words_written,    32'd0);
      byte_valid = 1'b1;
      byte_data  = 8'h56;
      tick(); tick(); tick();
      byte_valid = 1'b0;
      reset_n    = 1'b1;
      check("t5_nwr_rst", log_addr.size(), 32'd0);
      start_load(9'd1);
      send_word_fast(32'h0BADC0DE);
      check("t5_done2", done, 32'd1);
      tick();
      check("t5_nwr",  log_addr.size(), 32'd1);
      check("t5_waddr", (log_addr.size() > 0) ? log_addr[0] : 8'hxx, 32'd0);
      check("t5_wdata", (log_data.size() > 0) ? log_data[0] : 32'hxxxxxxxx, 32'h0BADC0DE);

      // start pulsed while collecting
      clear_log();
      start_load(9'd2);
      send_byte(8'h01);
      send_byte(8'h02);
      start      = 1'b1;
      word_count = 9'd5;
      tick();
      start      = 1'b0;
      check("t6_ready", byte_ready, 32'd1);
      send_byte(8'h03);
      send_byte(8'h04);
      check("t6_we",    mem_write_enable, 32'd1);
      check("t6_data0", mem_write_data,   32'h01020304);
      tick();
      send_word_fast(32'h05060708);
      check("t6_done",  done,          32'd1);
      check("t6_words", words_written, 32'd2);
      tick();
      check("t6_idle",  busy,            32'd0);
      check("t6_nwr",   log_addr.size(), 32'd2);
      check("t6_ndone", done_cnt,        32'd1);
      check("t6_data1", (log_data.size() > 1) ? log_data[1] : 32'hxxxxxxxx, 32'h05060708);
      check("t6_addr1", (log_addr.size() > 1) ? log_addr[1] : 8'hxx, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
